gba_fb_scanout: RTL and testbench

GBA_FB_SCANOUT -- requirements
Module: gba_fb_scanout

---
 rtl/gba_fb_pkg.sv | 60 ++++++
 rtl/gba_fb_vtiming.sv | 67 ++++++
 rtl/gba_fb_scanout.sv | 123 ++++++++++++
 tb/tb_gba_fb_scanout.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gba_fb_pkg.sv
// Shared definitions for the GBA framebuffer scan-out: default video timing,
// the 240x160 source geometry, pixel word layout and small helpers.
package gba_fb_pkg;

  // Default 640x480@60 timing (pixel clocks / lines)
  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;

  // Default placement of the scaled window and framebuffer read latency
  localparam int unsigned DEF_X_OFF    = 80;
  localparam int unsigned DEF_Y_OFF    = 80;
  localparam int unsigned DEF_RD_LAT   = 1;

  // Source image geometry; every source pixel is shown as a 2x2 block
  localparam int unsigned SRC_W = 240;
  localparam int unsigned SRC_H = 160;
  localparam int unsigned WIN_W = 2 * SRC_W;
  localparam int unsigned WIN_H = 2 * SRC_H;

  // Widths and colour field positions in the 15-bit framebuffer word
  localparam int unsigned CNT_W  = 12;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned PIX_W  = 15;
  localparam int unsigned COL_W  = 5;
  localparam int unsigned R_LSB  = 10;
  localparam int unsigned G_LSB  = 5;
  localparam int unsigned B_LSB  = 0;

  typedef logic [CNT_W-1:0]  cnt_t;
  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [PIX_W-1:0]  pix_t;
  typedef logic [COL_W-1:0]  col_t;

  // Timing flags for one counter state, all active-high
  typedef struct packed {
    logic de;
    logic hsync;
    logic vsync;
    logic frame;
  } tflags_t;

  // Start address of a source row: row * 240 as 128+64+32+16 shift-add
  function automatic addr_t row_base(input logic [7:0] row);
    addr_t r;
    r = addr_t'(row);
    return (r << 7) + (r << 6) + (r << 5) + (r << 4);
  endfunction

  // Extract one 5-bit colour channel from a framebuffer word
  function automatic col_t color_field(input pix_t px, input int unsigned lsb);
    return col_t'(px >> lsb);
  endfunction

endpackage

// File: rtl/gba_fb_vtiming.sv
// Raster counters and sync / display-enable decode for the scan-out.
// Flags describe the current counter state and are not delayed here.
module gba_fb_vtiming
  import gba_fb_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP
) (
  input  logic    i_clk,
  input  logic    i_rst,
  output cnt_t    o_h,
  output cnt_t    o_v,
  output tflags_t o_flags
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam cnt_t H_MAX   = cnt_t'(H_TOTAL - 1);
  localparam cnt_t V_MAX   = cnt_t'(V_TOTAL - 1);
  localparam cnt_t H_ACT   = cnt_t'(H_ACTIVE);
  localparam cnt_t V_ACT   = cnt_t'(V_ACTIVE);
  localparam cnt_t HS_LO   = cnt_t'(H_ACTIVE + H_FP);
  localparam cnt_t HS_HI   = cnt_t'(H_ACTIVE + H_FP + H_SYNC);
  localparam cnt_t VS_LO   = cnt_t'(V_ACTIVE + V_FP);
  localparam cnt_t VS_HI   = cnt_t'(V_ACTIVE + V_FP + V_SYNC);

  cnt_t    r_h;
  cnt_t    r_v;
  tflags_t w_flags;

  // Pixel counter wraps at end of line and advances the line counter
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_h <= '0;
      r_v <= '0;
    end else if (r_h == H_MAX) begin
      r_h <= '0;
      r_v <= (r_v == V_MAX) ? '0 : r_v + cnt_t'(1);
    end else begin
      r_h <= r_h + cnt_t'(1);
    end
  end

  // Decode active region, sync pulses and first-pixel marker
  // NOTE: defaulting every field first keeps this block free of latches.
  always_comb begin
    w_flags       = '0;
    w_flags.de    = (r_h < H_ACT) && (r_v < V_ACT);
    w_flags.hsync = (r_h >= HS_LO) && (r_h < HS_HI);
    w_flags.vsync = (r_v >= VS_LO) && (r_v < VS_HI);
    w_flags.frame = (r_h == '0) && (r_v == '0);
  end

  assign o_h     = r_h;
  assign o_v     = r_v;
  assign o_flags = w_flags;

endmodule

// File: rtl/gba_fb_scanout.sv
// Scans a 240x160 15-bit framebuffer out as a 2x-scaled 480x320 window
// inside a VGA raster. Address generation, flag alignment and colour
// output live here; raster timing comes from gba_fb_vtiming.
module gba_fb_scanout
  import gba_fb_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter int unsigned X_OFF    = DEF_X_OFF,
  parameter int unsigned Y_OFF    = DEF_Y_OFF,
  parameter int unsigned RD_LAT   = DEF_RD_LAT
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic        o_rden,
  output logic [15:0] o_rdaddr,
  input  logic [14:0] i_rddata,
  output logic [4:0]  o_R,
  output logic [4:0]  o_G,
  output logic [4:0]  o_B,
  output logic        o_hsync,
  output logic        o_vsync,
  output logic        o_de,
  output logic        o_frame
);

  // Flags travel RD_LAT+2 stages: address register, RAM latency, colour register
  localparam int unsigned PIPE_D = RD_LAT + 2;

  localparam cnt_t X_LO = cnt_t'(X_OFF);
  localparam cnt_t X_HI = cnt_t'(X_OFF + WIN_W);
  localparam cnt_t Y_LO = cnt_t'(Y_OFF);
  localparam cnt_t Y_HI = cnt_t'(Y_OFF + WIN_H);

  cnt_t    w_h;
  cnt_t    w_v;
  tflags_t w_tflags;
  logic    w_in_win;
  cnt_t    w_dx;
  cnt_t    w_dy;
  addr_t   w_addr;

  logic                  r_rden;
  addr_t                 r_rdaddr;
  tflags_t [PIPE_D-1:0]  r_tpipe;
  logic    [RD_LAT:0]    r_wpipe;
  pix_t                  r_rgb;

  gba_fb_vtiming #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_vtiming (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .o_h     (w_h),
    .o_v     (w_v),
    .o_flags (w_tflags)
  );

  // Window test and source address: each source pixel covers 2x2 screen pixels
  always_comb begin
    w_in_win = (w_h >= X_LO) && (w_h < X_HI) && (w_v >= Y_LO) && (w_v < Y_HI);
    w_dx     = w_h - X_LO;
    w_dy     = w_v - Y_LO;
    w_addr   = row_base(8'(w_dy >> 1)) + addr_t'(8'(w_dx >> 1));
  end

  // Read request register; address parks at zero outside the window
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rden   <= 1'b0;
      r_rdaddr <= '0;
    end else begin
      r_rden   <= w_in_win;
      r_rdaddr <= w_in_win ? w_addr : '0;
    end
  end

  // Delay lines aligning timing flags and window flag with returning data
  // NOTE: these short shift registers are cleared on reset so no stale
  // de/sync/frame from an abandoned frame leaks out after release.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_tpipe <= '0;
      r_wpipe <= '0;
    end else begin
      r_tpipe <= {r_tpipe[PIPE_D-2:0], w_tflags};
      r_wpipe <= {r_wpipe[RD_LAT-1:0], w_in_win};
    end
  end

  // Colour register: framebuffer word inside the window, black elsewhere
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rgb <= '0;
    end else begin
      r_rgb <= r_wpipe[RD_LAT] ? i_rddata : '0;
    end
  end

  assign o_rden   = r_rden;
  assign o_rdaddr = r_rdaddr;
  assign o_R      = color_field(r_rgb, R_LSB);
  assign o_G      = color_field(r_rgb, G_LSB);
  assign o_B      = color_field(r_rgb, B_LSB);
  assign o_de     = r_tpipe[PIPE_D-1].de;
  assign o_hsync  = ~r_tpipe[PIPE_D-1].hsync;
  assign o_vsync  = ~r_tpipe[PIPE_D-1].vsync;
  assign o_frame  = r_tpipe[PIPE_D-1].frame;

endmodule

// File: tb/tb_gba_fb_scanout.sv
// Scoreboard bench for gba_fb_scanout using a shrunken raster so whole
// frames fit in a short run. The reference derives (h,v) from the clock
// count since reset release and applies the raster/window rules directly.
`timescale 1ns/1ps
module tb_gba_fb_scanout;

  localparam int H_ACTIVE = 520;
  localparam int H_FP     = 8;
  localparam int H_SYNC   = 16;
  localparam int H_BP     = 16;
  localparam int V_ACTIVE = 36;
  localparam int V_FP     = 1;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 1;
  localparam int X_OFF    = 30;
  localparam int Y_OFF    = 4;
  localparam int RD_LAT   = 1;

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int FRAME   = H_TOTAL * V_TOTAL;
  localparam int LAT     = RD_LAT + 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [14:0] rddata = '0;
  logic        o_rden;
  logic [15:0] o_rdaddr;
  logic [4:0]  o_R, o_G, o_B;
  logic        o_hsync, o_vsync, o_de, o_frame;

  gba_fb_scanout #(
    .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
    .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP),
    .X_OFF    (X_OFF),    .Y_OFF (Y_OFF), .RD_LAT (RD_LAT)
  ) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .o_rden   (o_rden),
    .o_rdaddr (o_rdaddr),
    .i_rddata (rddata),
    .o_R      (o_R),
    .o_G      (o_G),
    .o_B      (o_B),
    .o_hsync  (o_hsync),
    .o_vsync  (o_vsync),
    .o_de     (o_de),
    .o_frame  (o_frame)
  );

  always #5 clk = ~clk;

  typedef struct {
    int h;
    int v;
    bit de;
    bit hs_n;
    bit vs_n;
    bit frame;
    bit rden;
    int addr;
    int rgb;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        adr_q[$];
  int          total = 0;
  int          bad = 0;
  int          n_state = 0;
  int unsigned salt;
  int          period_checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Content of the modelled framebuffer at a word address
  function automatic logic [14:0] ram_word(input int unsigned a);
    int unsigned x;
    x = (a * 32'd40503) ^ salt;
    return x[14:0];
  endfunction

  // Reference response for raster position (h,v)
  function automatic exp_t model(input int h, input int v);
    exp_t e;
    bit   win;
    e.h     = h;
    e.v     = v;
    e.de    = (h < H_ACTIVE) && (v < V_ACTIVE);
    e.hs_n  = !((h >= H_ACTIVE + H_FP) && (h < H_ACTIVE + H_FP + H_SYNC));
    e.vs_n  = !((v >= V_ACTIVE + V_FP) && (v < V_ACTIVE + V_FP + V_SYNC));
    e.frame = (h == 0) && (v == 0);
    win     = (h >= X_OFF) && (h < X_OFF + 480) && (v >= Y_OFF) && (v < Y_OFF + 320);
    e.rden  = win;
    e.addr  = win ? ((v - Y_OFF) / 2) * 240 + (h - X_OFF) / 2 : 0;
    e.rgb   = win ? int'(ram_word(e.addr)) : 0;
    return e;
  endfunction

  task automatic check_reset_vals(input string tag);
    check({tag, "_rden"},   32'(o_rden),   32'd0);
    check({tag, "_rdaddr"}, 32'(o_rdaddr), 32'd0);
    check({tag, "_rgb"},    32'({o_R, o_G, o_B}), 32'd0);
    check({tag, "_de"},     32'(o_de),     32'd0);
    check({tag, "_frame"},  32'(o_frame),  32'd0);
    check({tag, "_hsync"},  32'(o_hsync),  32'd1);
    check({tag, "_vsync"},  32'(o_vsync),  32'd1);
  endtask

  // Reference model: each clock edge out of reset consumes one raster state
  initial begin
    int   h;
    int   v;
    exp_t e;
    forever begin
      @(posedge clk);
      if (rst === 1'b0) begin
        h = n_state % H_TOTAL;
        v = (n_state / H_TOTAL) % V_TOTAL;
        e = model(h, v);
        exp_q.push_back(e);
        adr_q.push_back(e);
        n_state++;
      end
    end
  end

  // Framebuffer with RD_LAT clocks of read latency
  initial begin
    int hist[4];
    for (int i = 0; i < 4; i++) hist[i] = 0;
    forever begin
      @(negedge clk);
      for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = int'(o_rdaddr);
      rddata = ram_word(hist[RD_LAT]);
    end
  end

  // Monitor: compare outputs against the scoreboard every clock
  initial begin
    exp_t e;
    int   last_frame;
    int   hs_run;
    int   vs_run;
    bit   hs_prev;
    bit   vs_prev;
    last_frame = -1;
    hs_run = 0;
    vs_run = 0;
    hs_prev = 1'b1;
    vs_prev = 1'b1;
    forever begin
      @(negedge clk);
      if (rst !== 1'b0) begin
        check_reset_vals("in_reset");
        last_frame = -1;
        hs_run = 0;
        vs_run = 0;
        hs_prev = 1'b1;
        vs_prev = 1'b1;
      end else begin
        if (adr_q.size() > 0) begin
          e = adr_q.pop_front();
          check($sformatf("rden(%0d,%0d)", e.h, e.v),   32'(o_rden),   32'(e.rden));
          check($sformatf("rdaddr(%0d,%0d)", e.h, e.v), 32'(o_rdaddr), 32'(e.addr));
        end else begin
          check("rden_idle",   32'(o_rden),   32'd0);
          check("rdaddr_idle", 32'(o_rdaddr), 32'd0);
        end
        if (exp_q.size() >= LAT) begin
          e = exp_q.pop_front();
          check($sformatf("de(%0d,%0d)", e.h, e.v),    32'(o_de),    32'(e.de));
          check($sformatf("hsync(%0d,%0d)", e.h, e.v), 32'(o_hsync), 32'(e.hs_n));
          check($sformatf("vsync(%0d,%0d)", e.h, e.v), 32'(o_vsync), 32'(e.vs_n));
          check($sformatf("frame(%0d,%0d)", e.h, e.v), 32'(o_frame), 32'(e.frame));
          check($sformatf("rgb(%0d,%0d)", e.h, e.v),   32'({o_R, o_G, o_B}), 32'(e.rgb));
        end else begin
          check_reset_vals("fill");
        end
        if (o_frame === 1'b1) begin
          if (last_frame < 0) begin
            check("first_frame_delay", 32'(n_state), 32'(LAT));
          end else begin
            check("frame_period", 32'(n_state - last_frame), 32'(FRAME));
            period_checks++;
          end
          last_frame = n_state;
        end
        if (o_hsync === 1'b0) begin
          if (hs_prev) hs_run = 1;
          else if (hs_run > 0) hs_run++;
        end else if (!hs_prev && hs_run > 0) begin
          check("hsync_width", 32'(hs_run), 32'(H_SYNC));
          hs_run = 0;
        end
        hs_prev = o_hsync;
        if (o_vsync === 1'b0) begin
          if (vs_prev) vs_run = 1;
          else if (vs_run > 0) vs_run++;
        end else if (!vs_prev && vs_run > 0) begin
          check("vsync_width", 32'(vs_run), 32'(V_SYNC * H_TOTAL));
          vs_run = 0;
        end
        vs_prev = o_vsync;
      end
    end
  end

  // Assert reset between edges, verify the asynchronous clear, then release
  task automatic pulse_reset(input int cycles);
    @(posedge clk);
    #2;
    rst = 1'b1;
    exp_q.delete();
    adr_q.delete();
    n_state = 0;
    #1;
    check_reset_vals("async");
    repeat (cycles) @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  // Stimulus: power-on reset, free run, random mid-frame resets
  initial begin
    salt = $urandom;
    rst = 1'b1;
    repeat (10) @(posedge clk);
    #2;
    rst = 1'b0;
    repeat (FRAME + 50 + int'($urandom_range(0, 6000))) @(posedge clk);
    pulse_reset(3);
    repeat (FRAME + 100) @(posedge clk);
    repeat (int'($urandom_range(100, 3000))) @(posedge clk);
    pulse_reset(1 + int'($urandom_range(0, 3)));
    repeat (2000) @(posedge clk);
    #2;
    check("period_checks", 32'(period_checks), 32'd2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
